chirp_phase_sequencer: RTL and testbench
========================================

// Module: chirp_phase_sequencer
// PURPOSE
// Linear-FM chirp phase generator in the FMC150 DAC domain. It answers the radar pulse
// controller's chirp_init/chirp_enable handshake and returns chirp_ready, chirp_active and
// chirp_done. For each chirp it emits counter_max+1 phase words, which the downstream
// sin/cos LUT and DAC stage consume.
// Instantaneous frequency starts at freq_offset and increases by tuning_coef per sample.
// PARAMETERS
// PHASE_W      32  accumulator / frequency register width (bits)
// OUT_W        16  phase_out width; phase_out = phase_acc[PHASE_W-1 -: OUT_W]
// READY_DELAY  16  cycles after reset release before chirp_ready first asserts (>=1)
// PORTS
// aclk               in   1    sample clock (FMC150 DAC clock, 245.76 MHz)
// aresetn            in   1    asynchronous active-low reset
// chirp_parameters   in   128  [95:64] freq_offset, [63:32] tuning_coef, [31:0] counter_max
// chirp_init         in   1    start request pulse
// chirp_enable       in   1    level; must be high while chirping
// chirp_ready        out  1    high while idle and able to accept chirp_init
// chirp_active       out  1    high from parameter load through the last sample
// chirp_done         out  1    one-cycle pulse after the last sample of a completed chirp
// phase_out          out  OUT_W  truncated phase word
// phase_valid        out  1    phase_out is a valid sample this cycle
// sample_index       out  32   index of the current sample (0..counter_max)
// BEHAVIOUR
// - Reset: async assert; every output 0; state WARMUP; warm counter loaded with READY_DELAY.
// - All outputs are decoded from registers; there is no combinational path from input to output.
// - FSM states: WARMUP, IDLE, LOAD, RUN, DONE.
// - WARMUP: decrement the warm counter each cycle; when it reaches 0, go to IDLE.
//   chirp_ready first reads 1 READY_DELAY+1 cycles after reset release.
// - IDLE: chirp_ready=1. If chirp_init and chirp_enable are both high at an edge, go to LOAD.
//   chirp_init without chirp_enable is ignored.
// - LOAD: one cycle.
//   - Latch freq_offset, tuning_coef and counter_max into local registers.
//   - Set phase_acc<=0, freq<=freq_offset, sample_index<=0.
//   - chirp_ready=0, chirp_active=1, phase_valid=0.
// - RUN:
//   - phase_valid=1, chirp_active=1.
//   - Each cycle: phase_acc<=phase_acc+freq, freq<=freq+tuning_coef, sample_index<=sample_index+1.
//   - Sample n therefore carries phase_acc = n*freq_offset + tuning_coef*n*(n-1)/2, mod 2^PHASE_W.
//   - When sample_index==counter_max_latched, that sample is the last one; go to DONE.
//   - counter_max=0 gives exactly 1 sample. counter_max=0xFFFFFFFF gives 2^32 samples;
//     sample_index does not overflow because the exit compare fires first.
//   - Latency: init sampled at edge k; chirp_active=1 in cycle k+1; first phase_valid
//     (phase 0) in cycle k+2.
// - DONE: one cycle. chirp_done=1, chirp_active=0, phase_valid=0; then go to IDLE
//   (chirp_ready=1 the following cycle).
// - Abort: chirp_enable low during LOAD or RUN -> go to IDLE on the next edge.
//   No chirp_done pulse; phase_valid drops in that cycle. The controller tracks the abort
//   through the chirp_ready level.
// - Arithmetic is unsigned and wraps modulo 2^PHASE_W; overflow is not flagged.
// - chirp_parameters changes during LOAD+1..DONE are ignored; new values apply at the next LOAD.
// - chirp_init outside IDLE is ignored and is not queued.
// - chirp_init and the WARMUP->IDLE transition on the same edge: init is ignored because the
//   state was WARMUP.
// - Reset asserted mid-chirp: outputs clear immediately, FSM re-enters WARMUP, and no
//   chirp_done is generated.
// TESTING
// - Reset, READY_DELAY=16 -> chirp_ready low 16 cycles after release, high at cycle 17;
//   all other outputs stay 0.
// - off=0x00010000, coef=0, max=3; pulse init+enable -> active at k+1; phase_out 0,1,2,3 with
//   phase_valid in k+2..k+5; chirp_done at k+6 only; ready at k+7.
// - off=0, coef=0x00010000, max=4 -> phase_out 0,0,1,3,6; sample_index 0..4.
// - max=0 -> exactly one valid sample (phase 0), then a single chirp_done pulse.
// - off=0xFFFF0000, coef=0, max=2 -> phase_out 0x0000,0xFFFF,0xFFFE (wrap); change params
//   mid-run -> outputs unchanged.
// - Drop chirp_enable at the 2nd RUN cycle -> phase_valid 0 next cycle, no chirp_done, ready=1;
//   assert aresetn=0 mid-RUN -> all outputs 0 asynchronously, WARMUP again.

Source files
------------

// File: rtl/chirp_phase_sequencer_if.sv
// Handshake and sample bus between the radar pulse controller and the chirp phase sequencer.
// The controller drives the master modport and the sequencer uses the slave modport.
interface chirp_phase_sequencer_if #(
    parameter int OUT_W = 16
);
    logic [127:0]     chirp_parameters;
    logic             chirp_init;
    logic             chirp_enable;
    logic             chirp_ready;
    logic             chirp_active;
    logic             chirp_done;
    logic [OUT_W-1:0] phase_out;
    logic             phase_valid;
    logic [31:0]      sample_index;

    modport master (
        output chirp_parameters, chirp_init, chirp_enable,
        input  chirp_ready, chirp_active, chirp_done, phase_out, phase_valid, sample_index
    );

    modport slave (
        input  chirp_parameters, chirp_init, chirp_enable,
        output chirp_ready, chirp_active, chirp_done, phase_out, phase_valid, sample_index
    );
endinterface

// File: rtl/chirp_phase_sequencer.sv
// Linear-FM chirp phase generator: a quadratic phase accumulator stepped once per DAC sample,
// sequenced by a warmup/idle/load/run/done FSM with fully registered outputs.
module chirp_phase_sequencer #(
    parameter int PHASE_W     = 32,
    parameter int OUT_W       = 16,
    parameter int READY_DELAY = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    chirp_phase_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_WARMUP,
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [31:0]          r_warm;
    logic [PHASE_W-1:0]   r_acc;
    logic [PHASE_W-1:0]   r_freq;
    logic [PHASE_W-1:0]   r_coef;
    logic [31:0]          r_max;
    logic [31:0]          r_idx;
    logic                 r_ready;
    logic                 r_active;
    logic                 r_done;
    logic                 r_valid;

    logic [PHASE_W-1:0]   w_off;
    logic [PHASE_W-1:0]   w_coef;
    logic [31:0]          w_max;
    logic                 w_unused_params;

    assign w_off           = PHASE_W'(bus.chirp_parameters[95:64]);
    assign w_coef          = PHASE_W'(bus.chirp_parameters[63:32]);
    assign w_max           = bus.chirp_parameters[31:0];
    assign w_unused_params = ^bus.chirp_parameters[127:96];

    // Control FSM with registered outputs; the phase accumulator and index live here so
    // reset clears them along with the handshake outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_WARMUP;
            r_warm   <= 32'(READY_DELAY);
            r_acc    <= '0;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_WARMUP: begin
                    if (r_warm == '0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_warm <= r_warm - 32'd1;
                    end
                end
                S_IDLE: begin
                    if (bus.chirp_init && bus.chirp_enable) begin
                        r_state  <= S_LOAD;
                        r_ready  <= 1'b0;
                        r_active <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!bus.chirp_enable) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_active <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.chirp_enable) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_active <= 1'b0;
                        r_valid  <= 1'b0;
                    end else if (r_idx == r_max) begin
                        // Exit compare comes before the increment so a full 2^32-sample chirp never wraps the index.
                        r_state  <= S_DONE;
                        r_active <= 1'b0;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_acc <= r_acc + r_freq;
                        r_idx <= r_idx + 32'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_WARMUP;
                end
            endcase
        end
    end

    // Chirp parameters are only meaningful once LOAD has captured them, so they carry no reset.
    always_ff @(posedge aclk) begin
        if (r_state == S_LOAD) begin
            r_coef <= w_coef;
            r_max  <= w_max;
            r_freq <= w_off;
        end else if (r_state == S_RUN) begin
            r_freq <= r_freq + r_coef;
        end
    end

    assign bus.chirp_ready  = r_ready;
    assign bus.chirp_active = r_active;
    assign bus.chirp_done   = r_done;
    assign bus.phase_valid  = r_valid;
    assign bus.phase_out    = r_acc[PHASE_W-1 -: OUT_W];
    assign bus.sample_index = r_idx;

endmodule

// File: tb/tb_chirp_phase_sequencer.sv
// Directed bench for chirp_phase_sequencer: stimulus queues hand-computed samples and done
// pulses, a negedge monitor pops and compares every emitted sample or done pulse.
module tb_chirp_phase_sequencer;

    logic aclk;
    logic aresetn;
    int   checks;
    int   errors;

    typedef struct packed {
        logic        is_done;
        logic [15:0] phase;
        logic [31:0] idx;
    } exp_t;

    exp_t q[$];

    chirp_phase_sequencer_if #(.OUT_W(16)) bus ();

    chirp_phase_sequencer #(
        .PHASE_W     (32),
        .OUT_W       (16),
        .READY_DELAY (16)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge aclk);
            if (aresetn && (bus.phase_valid || bus.chirp_done)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got valid=%0b done=%0b phase=%h idx=%0d, expected no output",
                             bus.phase_valid, bus.chirp_done, bus.phase_out, bus.sample_index);
                end else begin
                    e = q.pop_front();
                    if (e.is_done)
                        ok = bus.chirp_done && !bus.phase_valid;
                    else
                        ok = bus.phase_valid && !bus.chirp_done &&
                             (bus.phase_out == e.phase) && (bus.sample_index == e.idx);
                    if (!ok) begin
                        errors++;
                        $display("FAIL sample: got valid=%0b done=%0b phase=%h idx=%0d, expected done=%0b phase=%h idx=%0d",
                                 bus.phase_valid, bus.chirp_done, bus.phase_out, bus.sample_index,
                                 e.is_done, e.phase, e.idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {ready, active, valid, done}
    function automatic logic [63:0] ctl();
        return 64'({bus.chirp_ready, bus.chirp_active, bus.phase_valid, bus.chirp_done});
    endfunction

    task automatic push_s(input logic [15:0] p, input logic [31:0] i);
        exp_t e;
        e.is_done = 1'b0;
        e.phase   = p;
        e.idx     = i;
        q.push_back(e);
    endtask

    task automatic push_d();
        exp_t e;
        e.is_done = 1'b1;
        e.phase   = '0;
        e.idx     = '0;
        q.push_back(e);
    endtask

    task automatic start_chirp(input logic [31:0] off, input logic [31:0] coef, input logic [31:0] max);
        bus.chirp_parameters = {32'h0, off, coef, max};
        bus.chirp_init       = 1'b1;
        bus.chirp_enable     = 1'b1;
        tick();
        bus.chirp_init       = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!bus.chirp_ready && n < budget) begin
            tick();
            n++;
        end
        check("wait_ready", 64'(bus.chirp_ready), 64'd1);
    endtask

    task automatic warmup_check(input string name);
        logic [15:0] low_ok;
        for (int i = 0; i < 16; i++) begin
            tick();
            low_ok[i] = (ctl() == 64'd0);
        end
        check({name, "_low16"}, 64'(low_ok), 64'hFFFF);
        tick();
        check({name, "_ready17"}, ctl(), 64'b1000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        aresetn              = 1'b0;
        bus.chirp_parameters = '0;
        bus.chirp_init       = 1'b0;
        bus.chirp_enable     = 1'b0;
        tick();
        tick();
        check("reset_outputs", {ctl()[3:0], bus.phase_out, bus.sample_index}, 64'd0);
        aresetn = 1'b1;
        warmup_check("warmup");

        // Constant frequency, 4 samples with exact handshake timing
        push_s(16'h0000, 0); push_s(16'h0001, 1); push_s(16'h0002, 2); push_s(16'h0003, 3); push_d();
        start_chirp(32'h0001_0000, 32'h0, 32'd3);
        check("t1_load", ctl(), 64'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t1_run%0d", i), ctl(), 64'b0110);
        end
        tick();
        check("t1_done", ctl(), 64'b0001);
        tick();
        check("t1_ready", ctl(), 64'b1000);

        // Init without enable is ignored
        bus.chirp_init   = 1'b1;
        bus.chirp_enable = 1'b0;
        tick();
        bus.chirp_init   = 1'b0;
        tick();
        check("init_no_enable", ctl(), 64'b1000);

        // Quadratic phase from tuning_coef
        push_s(16'd0, 0); push_s(16'd0, 1); push_s(16'd1, 2); push_s(16'd3, 3); push_s(16'd6, 4); push_d();
        start_chirp(32'h0, 32'h0001_0000, 32'd4);
        wait_ready(20);
        check("t2_idle", ctl(), 64'b1000);

        // Single-sample chirp
        push_s(16'h0000, 0); push_d();
        start_chirp(32'h1234_5678, 32'h0, 32'd0);
        check("t3_load", ctl(), 64'b0100);
        tick();
        check("t3_run", ctl(), 64'b0110);
        tick();
        check("t3_done", ctl(), 64'b0001);
        tick();
        check("t3_ready", ctl(), 64'b1000);

        // Wrapping accumulator; parameter changes after LOAD have no effect
        push_s(16'h0000, 0); push_s(16'hFFFF, 1); push_s(16'hFFFE, 2); push_d();
        start_chirp(32'hFFFF_0000, 32'h0, 32'd2);
        tick();
        bus.chirp_parameters = {32'h0, 32'h0001_0000, 32'h0001_0000, 32'd50};
        wait_ready(20);
        check("t4_idle", ctl(), 64'b1000);

        // Abort by dropping enable on the second RUN cycle
        push_s(16'h0000, 0); push_s(16'h0001, 1);
        start_chirp(32'h0001_0000, 32'h0, 32'd10);
        tick();
        tick();
        bus.chirp_enable = 1'b0;
        tick();
        check("abort_idle", ctl(), 64'b1000);
        tick();
        tick();
        check("abort_no_done", ctl(), 64'b1000);

        // Async reset in the middle of RUN
        push_s(16'h0000, 0); push_s(16'h0001, 1);
        start_chirp(32'h0001_0000, 32'h0, 32'd10);
        tick();
        tick();
        @(negedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check("async_reset", {ctl()[3:0], bus.phase_out, bus.sample_index}, 64'd0);
        bus.chirp_enable = 1'b0;
        tick();
        aresetn = 1'b1;
        warmup_check("rewarm");

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
